soc_wrapper: RTL and testbench



---
 rtl/soc_wrapper_pkg.sv | 32 +++
 rtl/soc_wrapper_if.sv | 35 +++
 rtl/prog_uart_rx.sv | 94 +++++++++
 rtl/soc_wrapper.sv | 182 ++++++++++++++++++
 tb/tb_soc_wrapper.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/soc_wrapper_pkg.sv
`default_nettype none
// ============================================================================
// soc_wrapper_pkg : widths, loader receiver states and baud-divisor helpers
// Rev 1.0
// ============================================================================
package soc_wrapper_pkg;

  localparam int BYTE_W          = 8;
  localparam int WORD_W          = 32;
  localparam int BYTES_PER_WORD  = WORD_W / BYTE_W;
  localparam int BCNT_W          = $clog2(BYTES_PER_WORD);
  localparam int QSPI_W          = 4;
  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  function automatic int calc_cpb(input int freq_hz, input int baud);
    return freq_hz / baud;
  endfunction

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/soc_wrapper_if.sv
`default_nettype none
// ============================================================================
// soc_wrapper_if : wrapper-to-core bus (program memory write port, UART, QSPI)
// Rev 1.0
// ============================================================================
interface soc_wrapper_if
  import soc_wrapper_pkg::*;
#(
  parameter int PROG_ADDR_W = 12
);

  logic                   core_resetn;
  logic                   prog_we;
  logic [PROG_ADDR_W-1:0] prog_addr;
  logic [WORD_W-1:0]      prog_wdata;
  logic                   uart_rx;
  logic                   uart_tx;
  logic                   qspi_sclk;
  logic                   qspi_cs_n;
  logic [QSPI_W-1:0]      qspi_do;
  logic [QSPI_W-1:0]      qspi_oe;
  logic [QSPI_W-1:0]      qspi_di;

  modport master (
    output core_resetn, prog_we, prog_addr, prog_wdata, uart_rx, qspi_di,
    input  uart_tx, qspi_sclk, qspi_cs_n, qspi_do, qspi_oe
  );

  modport slave (
    input  core_resetn, prog_we, prog_addr, prog_wdata, uart_rx, qspi_di,
    output uart_tx, qspi_sclk, qspi_cs_n, qspi_do, qspi_oe
  );

endinterface
`default_nettype wire

// File: rtl/prog_uart_rx.sv
`default_nettype none
// ============================================================================
// prog_uart_rx : tick-driven 8N1 receiver for the firmware loader
// Rev 1.0
// ============================================================================
module prog_uart_rx
  import soc_wrapper_pkg::*;
#(
  parameter int CPB = 5208
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              en,
  input  logic              rx,
  output logic              byte_valid,
  output logic [BYTE_W-1:0] byte_data
);

  localparam int               CNT_W    = cnt_width(CPB);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'((CPB / 2) - 1);

  rx_state_t          r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_bit_idx;
  logic               r_rx_prev;
  logic               r_byte_valid;
  logic [BYTE_W-1:0]  r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RX_IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_rx_prev    <= 1'b1;
      r_byte_valid <= 1'b0;
      r_data       <= '0;
    end else if (tick) begin
      r_rx_prev    <= rx;
      r_byte_valid <= 1'b0;
      if (!en) begin
        r_state <= RX_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          RX_IDLE: begin
            if (r_rx_prev && !rx) begin
              r_state <= RX_START;
              r_cnt   <= '0;
            end
          end
          RX_START: begin
            // Re-check mid start bit so a short glitch does not open a frame.
            if (r_cnt == HALF_BIT) begin
              r_cnt     <= '0;
              r_bit_idx <= '0;
              r_state   <= rx ? RX_IDLE : RX_DATA;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          RX_DATA: begin
            if (r_cnt == FULL_BIT) begin
              r_cnt             <= '0;
              r_data[r_bit_idx] <= rx;
              r_bit_idx         <= r_bit_idx + 3'd1;
              if (r_bit_idx == 3'd7) begin
                r_state <= RX_STOP;
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          RX_STOP: begin
            if (r_cnt == FULL_BIT) begin
              r_cnt        <= '0;
              r_state      <= RX_IDLE;
              r_byte_valid <= rx;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: r_state <= RX_IDLE;
        endcase
      end
    end
  end

  assign byte_valid = r_byte_valid;
  assign byte_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/soc_wrapper.sv
`default_nettype none
// ============================================================================
// soc_wrapper : core clock divider, UART firmware loader and run-mode pin mux
// Optional echo of loaded bytes on tx: PROGRAMMER_ECHO_EN.  Rev 1.0
// ============================================================================
module soc_wrapper
  import soc_wrapper_pkg::*;
#(
  parameter int IN_FREQ_HZ  = 100_000_000,
  parameter int CLK_DIV     = 2,
  parameter int FREQ_HZ     = 50_000_000,
  parameter int PROG_BAUD   = 9600,
  parameter int PROG_ADDR_W = 12
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rx,
  output logic              tx,
  output logic              qspi_sclk_out,
  output logic              qspi_cs_n_out,
  inout  wire  [QSPI_W-1:0] qspi_data,
  input  logic              programmer_mode,
  output logic              clk_o,
  soc_wrapper_if.master     core
);

  // A zero FREQ_HZ derives the core rate from the board clock instead.
  localparam int CORE_HZ  = (FREQ_HZ > 0) ? FREQ_HZ : IN_FREQ_HZ / CLK_DIV;
  localparam int CPB      = calc_cpb(CORE_HZ, PROG_BAUD);
  localparam int HALF_DIV = (CLK_DIV > 1) ? CLK_DIV / 2 : 1;
  localparam int DIV_W    = cnt_width(HALF_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);

  logic [DIV_W-1:0]              r_div_cnt;
  logic                          r_clk_o;
  logic                          w_div_wrap;
  logic                          w_tick;
  logic                          r_rx_meta;
  logic                          r_rx_sync;
  logic                          r_mode_meta;
  logic                          r_mode_sync;
  logic                          w_byte_valid;
  logic [BYTE_W-1:0]             w_byte_data;
  logic                          w_byte_take;
  logic                          w_word_done;
  logic [BCNT_W-1:0]             r_byte_cnt;
  logic [WORD_W-BYTE_W-1:0]      r_word;
  logic [PROG_ADDR_W-1:0]        r_word_idx;
  logic [PROG_ADDR_W-1:0]        r_prog_addr;
  logic [WORD_W-1:0]             r_prog_wdata;
  logic                          r_prog_we;
  logic                          w_echo_tx;
  logic [QSPI_W-1:0]             w_qspi_oe;

  assign w_div_wrap = (r_div_cnt == DIV_LAST);
  assign w_tick     = w_div_wrap & ~r_clk_o;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_div_cnt <= '0;
      r_clk_o   <= 1'b0;
    end else if (w_div_wrap) begin
      r_div_cnt <= '0;
      r_clk_o   <= ~r_clk_o;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  assign clk_o = r_clk_o;

  // Mode sync resets to programmer mode so pins stay quiet until it settles.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rx_meta   <= 1'b1;
      r_rx_sync   <= 1'b1;
      r_mode_meta <= 1'b1;
      r_mode_sync <= 1'b1;
    end else if (w_tick) begin
      r_rx_meta   <= rx;
      r_rx_sync   <= r_rx_meta;
      r_mode_meta <= programmer_mode;
      r_mode_sync <= r_mode_meta;
    end
  end

  prog_uart_rx #(
    .CPB (CPB)
  ) u_prog_uart_rx (
    .clk        (clk),
    .rst_n      (resetn),
    .tick       (w_tick),
    .en         (r_mode_sync),
    .rx         (r_rx_sync),
    .byte_valid (w_byte_valid),
    .byte_data  (w_byte_data)
  );

  assign w_byte_take = w_byte_valid & r_mode_sync;
  assign w_word_done = (r_byte_cnt == BCNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_byte_cnt   <= '0;
      r_word       <= '0;
      r_word_idx   <= '0;
      r_prog_addr  <= '0;
      r_prog_wdata <= '0;
      r_prog_we    <= 1'b0;
    end else if (w_tick) begin
      r_prog_we <= 1'b0;
      if (w_byte_take) begin
        if (w_word_done) begin
          r_prog_we    <= 1'b1;
          r_prog_addr  <= r_word_idx;
          r_prog_wdata <= {w_byte_data, r_word};
          r_word_idx   <= r_word_idx + PROG_ADDR_W'(1);
          r_byte_cnt   <= '0;
        end else begin
          r_word[r_byte_cnt*BYTE_W +: BYTE_W] <= w_byte_data;
          r_byte_cnt                          <= r_byte_cnt + BCNT_W'(1);
        end
      end else if (!r_mode_sync) begin
        // Leaving programmer mode abandons any partial word; word_idx is kept.
        r_byte_cnt <= '0;
      end
    end
  end

`ifdef PROGRAMMER_ECHO_EN
  localparam int LEFT_W = cnt_width(UART_FRAME_BITS + 1);
  localparam int CPB_W  = cnt_width(CPB);

  logic [UART_FRAME_BITS-1:0] r_echo_sh;
  logic [LEFT_W-1:0]          r_echo_left;
  logic [CPB_W-1:0]           r_echo_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_echo_sh   <= '1;
      r_echo_left <= '0;
      r_echo_cnt  <= '0;
    end else if (w_tick) begin
      if (w_byte_take) begin
        r_echo_sh   <= {1'b1, w_byte_data, 1'b0};
        r_echo_left <= LEFT_W'(UART_FRAME_BITS);
        r_echo_cnt  <= '0;
      end else if (r_echo_left != '0) begin
        if (r_echo_cnt == CPB_W'(CPB - 1)) begin
          r_echo_cnt  <= '0;
          r_echo_sh   <= {1'b1, r_echo_sh[UART_FRAME_BITS-1:1]};
          r_echo_left <= r_echo_left - LEFT_W'(1);
        end else begin
          r_echo_cnt <= r_echo_cnt + CPB_W'(1);
        end
      end
    end
  end

  assign w_echo_tx = r_echo_sh[0];
`else
  assign w_echo_tx = 1'b1;
`endif

  assign core.core_resetn = resetn & ~r_mode_sync;
  assign core.prog_we     = r_prog_we;
  assign core.prog_addr   = r_prog_addr;
  assign core.prog_wdata  = r_prog_wdata;
  assign core.uart_rx     = r_mode_sync ? 1'b1 : r_rx_sync;
  assign core.qspi_di     = qspi_data;

  assign tx            = r_mode_sync ? w_echo_tx : core.uart_tx;
  assign qspi_sclk_out = ~r_mode_sync & core.qspi_sclk;
  assign qspi_cs_n_out = r_mode_sync | core.qspi_cs_n;
  assign w_qspi_oe     = r_mode_sync ? '0 : core.qspi_oe;

  for (genvar i = 0; i < QSPI_W; i++) begin : g_qspi
    assign qspi_data[i] = w_qspi_oe[i] ? core.qspi_do[i] : 1'bz;
  end

endmodule
`default_nettype wire

// File: tb/tb_soc_wrapper.sv
`default_nettype none
// tb_soc_wrapper: randomized loader and pin-mux bench with a byte-level reference model.
module tb_soc_wrapper;
  import soc_wrapper_pkg::*;

  localparam int CLK_DIV  = 2;
  localparam int FREQ     = 50_000_000;
  localparam int BAUD     = 3_125_000;
  localparam int AW       = 2;
  localparam int CPB      = FREQ / BAUD;
  localparam int BIT_CLKS = CPB * CLK_DIV;

  logic clk             = 1'b0;
  logic resetn          = 1'b0;
  logic rx              = 1'b1;
  logic programmer_mode = 1'b0;
  wire  tx, qspi_sclk_out, qspi_cs_n_out, clk_o;
  wire  [QSPI_W-1:0] qspi_data;

  soc_wrapper_if #(.PROG_ADDR_W(AW)) core_bus ();

  soc_wrapper #(
    .IN_FREQ_HZ  (100_000_000),
    .CLK_DIV     (CLK_DIV),
    .FREQ_HZ     (FREQ),
    .PROG_BAUD   (BAUD),
    .PROG_ADDR_W (AW)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .rx              (rx),
    .tx              (tx),
    .qspi_sclk_out   (qspi_sclk_out),
    .qspi_cs_n_out   (qspi_cs_n_out),
    .qspi_data       (qspi_data),
    .programmer_mode (programmer_mode),
    .clk_o           (clk_o),
    .core            (core_bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_writes = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  bit          m_prog = 1'b0;
  int          m_cnt  = 0;
  int          m_idx  = 0;
  logic [31:0] m_word = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: little-endian packing, index modulo the memory depth.
  task automatic model_byte(input logic [7:0] b);
    wr_t w;
    m_word[8*m_cnt +: 8] = b;
    if (m_cnt == 3) begin
      w.addr = 32'(m_idx);
      w.data = m_word;
      exp_q.push_back(w);
      m_idx = (m_idx + 1) % (1 << AW);
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
  endtask

  always @(negedge clk) begin
    if (clk_o === 1'b1 && core_bus.prog_we === 1'b1) begin
      n_writes++;
      check("we_expected", 32'(exp_q.size() > 0 ? 1 : 0), 32'd1);
      if (exp_q.size() > 0) begin
        wr_t e;
        e = exp_q.pop_front();
        check("we_addr", 32'(core_bus.prog_addr), e.addr);
        check("we_data", core_bus.prog_wdata, e.data);
      end
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n * CLK_DIV) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    if (m_prog && stop_ok) model_byte(b);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = stop_ok;
    repeat (BIT_CLKS) @(negedge clk);
    rx = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic set_mode(input bit v);
    programmer_mode = v;
    wait_ticks(4);
    m_prog = v;
    if (!v) m_cnt = 0;
    check("mode_core_resetn", 32'(core_bus.core_resetn), 32'(!v));
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    m_idx = 0;
    m_cnt = 0;
    wait_ticks(4);
    m_prog = programmer_mode;
  endtask

  task automatic core_idle();
    core_bus.uart_tx   = 1'b1;
    core_bus.qspi_sclk = 1'b0;
    core_bus.qspi_cs_n = 1'b1;
    core_bus.qspi_do   = '0;
    core_bus.qspi_oe   = '0;
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] v;
    logic [7:0] got_b;
    int rises, highs, w;
    bit prev, low_seen;

    core_idle();
    repeat (4) @(negedge clk);
    check("rst_clk_o", 32'(clk_o), 32'd0);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_cs_n", 32'(qspi_cs_n_out), 32'd1);
    check("rst_sclk", 32'(qspi_sclk_out), 32'd0);
    check("rst_core_resetn", 32'(core_bus.core_resetn), 32'd0);
    check("rst_prog_we", 32'(core_bus.prog_we), 32'd0);
    resetn = 1'b1;

    // Core clock: half the board rate, 50% duty.
    rises = 0; highs = 0; prev = clk_o;
    repeat (100) begin
      @(negedge clk);
      if (clk_o && !prev) rises++;
      if (clk_o) highs++;
      prev = clk_o;
    end
    check("clk_o_rises", 32'(rises), 32'd50);
    check("clk_o_highs", 32'(highs), 32'd50);
    wait_ticks(50);
    check("run_tx_idle", 32'(tx), 32'd1);
    check("run_cs_n_idle", 32'(qspi_cs_n_out), 32'd1);
    check("run_core_resetn", 32'(core_bus.core_resetn), 32'd1);

    // Run mode pass-through.
    repeat (4) begin
      v = 4'($urandom);
      core_bus.uart_tx   = v[0];
      core_bus.qspi_sclk = v[1];
      core_bus.qspi_cs_n = v[2];
      rx                 = v[3];
      wait_ticks(4);
      check("pass_tx", 32'(tx), 32'(v[0]));
      check("pass_sclk", 32'(qspi_sclk_out), 32'(v[1]));
      check("pass_cs_n", 32'(qspi_cs_n_out), 32'(v[2]));
      check("pass_rx", 32'(core_bus.uart_rx), 32'(v[3]));
    end
    core_idle();
    rx = 1'b1;
    wait_ticks(4);

    // Programmer mode isolates the pins and loads one word.
    set_mode(1'b1);
    core_bus.uart_tx = 1'b0; core_bus.qspi_sclk = 1'b1; core_bus.qspi_cs_n = 1'b0;
    wait_ticks(1);
    check("prog_tx", 32'(tx), 32'd1);
    check("prog_sclk", 32'(qspi_sclk_out), 32'd0);
    check("prog_cs_n", 32'(qspi_cs_n_out), 32'd1);
    check("prog_core_rx", 32'(core_bus.uart_rx), 32'd1);
    core_idle();
    w = n_writes;
    send_byte(8'h13, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    check("t2_writes", 32'(n_writes - w), 32'd1);
    check("t2_pending", 32'(exp_q.size()), 32'd0);

    // Four words from index 0; the last write wraps the index.
    do_reset();
    w = n_writes;
    for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b1);
    check("t3_writes", 32'(n_writes - w), 32'd4);
    set_mode(1'b0);
    do_reset();
    check("t3_released", 32'(core_bus.core_resetn), 32'd1);

    // Framing error is dropped; next word lands at index 0.
    set_mode(1'b1);
    send_byte(8'($urandom), 1'b0);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1);
    check("t4_pending", 32'(exp_q.size()), 32'd0);

    // Partial word discarded on mode exit.
    do_reset();
    w = n_writes;
    send_byte(8'($urandom), 1'b1); send_byte(8'($urandom), 1'b1);
    set_mode(1'b0);
    check("t5_no_write", 32'(n_writes - w), 32'd0);
    set_mode(1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1);
    check("t5_writes", 32'(n_writes - w), 32'd1);

    // Random traffic with mode toggles and framing errors.
    for (int k = 0; k < 24; k++) begin
      if (k % 6 == 5) set_mode(!m_prog);
      send_byte(8'($urandom), ($urandom_range(0, 7) != 0));
      wait_ticks($urandom_range(0, 12));
    end
    check("rand_pending", 32'(exp_q.size()), 32'd0);

    set_mode(1'b1);
`ifdef PROGRAMMER_ECHO_EN
    fork
      send_byte(8'hA5, 1'b1);
      begin
        w = 0;
        while (tx !== 1'b0 && w < 20 * BIT_CLKS) begin
          @(negedge clk);
          w++;
        end
        check("echo_start_seen", 32'(tx), 32'd0);
        repeat (BIT_CLKS / 2) @(negedge clk);
        check("echo_start_bit", 32'(tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT_CLKS) @(negedge clk);
          got_b[i] = tx;
        end
        check("echo_byte", 32'(got_b), 32'hA5);
        repeat (BIT_CLKS) @(negedge clk);
        check("echo_stop_bit", 32'(tx), 32'd1);
      end
    join
`else
    low_seen = 1'b0;
    fork
      send_byte(8'hA5, 1'b1);
      repeat (11 * BIT_CLKS) begin
        @(negedge clk);
        if (tx !== 1'b1) low_seen = 1'b1;
      end
    join
    check("noecho_tx_high", 32'(low_seen), 32'd0);
`endif

    wait_ticks(8);
    check("final_pending", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
